syncn_decoder_mc: RTL and testbench

- Parametrised, multi-channel SYNC~ decoder for the JESD204B transmitter control path.
- Each SYNC~ input is sampled on the device clock and qualified by the frame strobe.
- Low pulses are classified as error reports or re-initialization requests, with release events flagged.
- Per-channel results are aggregated for multipoint links; outputs feed the TX link FSM (CGS/ILAS restart) and error-monitor logic.

---
 rtl/jesd_ctrl_pkg.sv | 30 +++
 rtl/syncn_chan.sv | 119 +++++++++++
 rtl/syncn_decoder_mc.sv | 111 +++++++++++
 tb/tb_syncn_decoder_mc.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jesd_ctrl_pkg
//
// Shared definitions for the JESD204B transmitter control path.
//
// Contents:
//   sync_state_t        - per-channel SYNC~ decoder state encoding
//   DEFAULT_REQ_FRAMES  - default number of consecutive low frame strobes
//                         that turn a low SYNC~ pulse into a sync request
//   sync_cnt_width()    - width of a frame counter able to hold req_frames
// ---------------------------------------------------------------------------
package jesd_ctrl_pkg;

    // IDLE: SYNC~ high. LOW: SYNC~ low, still an error report candidate.
    // REQ: SYNC~ held low long enough to be a re-initialization request.
    typedef enum logic [1:0] {
        SYNC_IDLE = 2'd0,
        SYNC_LOW  = 2'd1,
        SYNC_REQ  = 2'd2
    } sync_state_t;

    localparam int DEFAULT_REQ_FRAMES = 4;

    // The frame counter must be able to represent REQ_FRAMES itself,
    // since that is the value at which it saturates.
    function automatic int sync_cnt_width(input int req_frames);
        return $clog2(req_frames + 1);
    endfunction

endpackage

// File: rtl/syncn_chan.sv
// ---------------------------------------------------------------------------
// syncn_chan
//
// Single-channel SYNC~ decoder. Classifies a low pulse on sync_n as either
// an error report (released before REQ_FRAMES frame strobes) or a
// re-initialization request (held low for REQ_FRAMES frame strobes), and
// flags the end of a request with a release pulse.
//
// Parameters:
//   REQ_FRAMES     - low frame strobes that classify a pulse as a request
//
// Ports:
//   clk            in   device clock
//   rst            in   synchronous active-high reset
//   frame_clk      in   frame strobe, one clk cycle per frame
//   sync_n         in   SYNC~ for this channel, active low
//   err_reporting  out  registered: channel is in LOW
//   sync_request   out  registered: channel is in REQ
//   err_pulse      out  registered one-cycle pulse: completed error report
//   sync_release   out  registered one-cycle pulse: request ended
//   req_nxt        out  combinational next-state REQ flag, for aggregation
//   release_nxt    out  combinational next-cycle release flag, for aggregation
// ---------------------------------------------------------------------------
module syncn_chan
    import jesd_ctrl_pkg::*;
#(
    parameter int REQ_FRAMES = DEFAULT_REQ_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    input  logic sync_n,
    output logic err_reporting,
    output logic sync_request,
    output logic err_pulse,
    output logic sync_release,
    output logic req_nxt,
    output logic release_nxt
);

    localparam int              FCW     = sync_cnt_width(REQ_FRAMES);
    localparam logic [FCW-1:0]  REQ_CNT = FCW'(REQ_FRAMES);

    sync_state_t    state;
    sync_state_t    state_nxt;
    logic [FCW-1:0] frame_cnt;
    logic [FCW-1:0] frame_cnt_nxt;
    logic [FCW-1:0] frame_cnt_inc;
    logic           err_nxt;
    logic           rel_nxt;

    assign frame_cnt_inc = frame_cnt + FCW'(1);

    // Next-state decode. A rising SYNC~ always wins over a frame strobe in
    // the same cycle, so the strobe is only counted while SYNC~ stays low.
    // A LOW that ends without any counted strobe is treated as a glitch.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        err_nxt       = 1'b0;
        rel_nxt       = 1'b0;
        case (state)
            SYNC_IDLE: begin
                if (!sync_n) begin
                    state_nxt     = SYNC_LOW;
                    frame_cnt_nxt = frame_clk ? FCW'(1) : '0;
                end
            end
            SYNC_LOW: begin
                if (sync_n) begin
                    state_nxt     = SYNC_IDLE;
                    frame_cnt_nxt = '0;
                    err_nxt       = (frame_cnt != '0);
                end else if (frame_clk && (frame_cnt < REQ_CNT)) begin
                    frame_cnt_nxt = frame_cnt_inc;
                    if (frame_cnt_inc == REQ_CNT) begin
                        state_nxt = SYNC_REQ;
                    end
                end
            end
            SYNC_REQ: begin
                if (sync_n) begin
                    state_nxt     = SYNC_IDLE;
                    frame_cnt_nxt = '0;
                    rel_nxt       = 1'b1;
                end
            end
            default: begin
                state_nxt     = SYNC_IDLE;
                frame_cnt_nxt = '0;
            end
        endcase
    end

    assign req_nxt     = (state_nxt == SYNC_REQ);
    assign release_nxt = rel_nxt;

    // State, counter and all outputs are registered together. Level outputs
    // are decoded from the next state so they line up with the state itself;
    // reset drops any pending pulse so a mid-pulse reset is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SYNC_IDLE;
            frame_cnt     <= '0;
            err_reporting <= 1'b0;
            sync_request  <= 1'b0;
            err_pulse     <= 1'b0;
            sync_release  <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame_cnt     <= frame_cnt_nxt;
            err_reporting <= (state_nxt == SYNC_LOW);
            sync_request  <= (state_nxt == SYNC_REQ);
            err_pulse     <= err_nxt;
            sync_release  <= rel_nxt;
        end
    end

endmodule

// File: rtl/syncn_decoder_mc.sv
// ---------------------------------------------------------------------------
// syncn_decoder_mc
//
// Multi-channel SYNC~ decoder for the JESD204B transmitter control path.
// One syncn_chan per SYNC~ input; this level aggregates the per-channel
// results for multipoint links.
//
// Optional feature (macro SYNCN_ERR_CNT_EN): per-channel saturating error
// report counters with a shared clear. When the macro is undefined the
// counter ports and logic are absent.
//
// Parameters:
//   NUM_SYNC            - number of SYNC~ inputs (1..8)
//   REQ_FRAMES          - low frame strobes that make a sync request (2..15)
//   CNT_W               - width of each error counter (optional feature)
//
// Ports:
//   clk                 in   device clock (2x frame rate)
//   rst                 in   synchronous active-high reset
//   frame_clk           in   frame strobe
//   i_sync_n            in   SYNC~ per channel, active low
//   i_err_cnt_clr       in   clear all error counters (SYNCN_ERR_CNT_EN)
//   o_err_cnt           out  error counters, channel n at [n*CNT_W +: CNT_W]
//                            (SYNCN_ERR_CNT_EN)
//   o_sync_request_tx   out  per-channel request level
//   o_err_reporting     out  per-channel SYNC~-low-not-yet-request level
//   o_err_pulse         out  per-channel completed error report pulse
//   o_sync_release      out  per-channel request-ended pulse
//   o_sync_request_any  out  OR of all request levels
//   o_sync_release_all  out  pulse when the last requesting channel releases
// ---------------------------------------------------------------------------
module syncn_decoder_mc
    import jesd_ctrl_pkg::*;
#(
    parameter int NUM_SYNC   = 2,
    parameter int REQ_FRAMES = DEFAULT_REQ_FRAMES,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_clk,
    input  logic [NUM_SYNC-1:0]       i_sync_n,
`ifdef SYNCN_ERR_CNT_EN
    input  logic                      i_err_cnt_clr,
    output logic [NUM_SYNC*CNT_W-1:0] o_err_cnt,
`endif
    output logic [NUM_SYNC-1:0]       o_sync_request_tx,
    output logic [NUM_SYNC-1:0]       o_err_reporting,
    output logic [NUM_SYNC-1:0]       o_err_pulse,
    output logic [NUM_SYNC-1:0]       o_sync_release,
    output logic                      o_sync_request_any,
    output logic                      o_sync_release_all
);

    logic [NUM_SYNC-1:0] req_nxt;
    logic [NUM_SYNC-1:0] release_nxt;

    // One independent decoder per SYNC~ input; there is no cross-channel
    // skew compensation, each channel sees only its own SYNC~.
    for (genvar g = 0; g < NUM_SYNC; g++) begin : g_chan
        syncn_chan #(
            .REQ_FRAMES (REQ_FRAMES)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .frame_clk     (frame_clk),
            .sync_n        (i_sync_n[g]),
            .err_reporting (o_err_reporting[g]),
            .sync_request  (o_sync_request_tx[g]),
            .err_pulse     (o_err_pulse[g]),
            .sync_release  (o_sync_release[g]),
            .req_nxt       (req_nxt[g]),
            .release_nxt   (release_nxt[g])
        );
    end

    // Aggregates are built from the channels' next-state flags so that they
    // are registered in the same edge as the per-channel outputs. A release
    // only counts as "all released" when no channel remains in REQ; channels
    // that are merely low do not hold it off.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sync_request_any <= 1'b0;
            o_sync_release_all <= 1'b0;
        end else begin
            o_sync_request_any <= |req_nxt;
            o_sync_release_all <= (|release_nxt) && !(|req_nxt);
        end
    end

`ifdef SYNCN_ERR_CNT_EN
    // Per-channel error report counters. Each counts registered error
    // pulses and sticks at all-ones; a clear wins over a simultaneous pulse.
    for (genvar g = 0; g < NUM_SYNC; g++) begin : g_err_cnt
        logic [CNT_W-1:0] err_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                err_cnt <= '0;
            end else if (i_err_cnt_clr) begin
                err_cnt <= '0;
            end else if (o_err_pulse[g] && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end

        assign o_err_cnt[g*CNT_W +: CNT_W] = err_cnt;
    end
`endif

endmodule

// File: tb/tb_syncn_decoder_mc.sv
// ---------------------------------------------------------------------------
// tb_syncn_decoder_mc
//
// Self-checking bench for syncn_decoder_mc with NUM_SYNC=2, REQ_FRAMES=4,
// CNT_W=2. A reference model tracks each channel as "currently inside a low
// run, with this many strobes seen" and derives every expected output from
// that view. Error counter checks are built when SYNCN_ERR_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_syncn_decoder_mc;

    localparam int NS   = 2;
    localparam int RF   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_clk;
    logic [NS-1:0]   i_sync_n;
`ifdef SYNCN_ERR_CNT_EN
    logic            i_err_cnt_clr;
    logic [NS*CW-1:0] o_err_cnt;
`endif
    logic [NS-1:0]   o_sync_request_tx;
    logic [NS-1:0]   o_err_reporting;
    logic [NS-1:0]   o_err_pulse;
    logic [NS-1:0]   o_sync_release;
    logic            o_sync_request_any;
    logic            o_sync_release_all;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit            low_active [NS];
    int            strobes    [NS];
    int            exp_cnt    [NS];
    logic [NS-1:0] exp_req    = '0;
    logic [NS-1:0] exp_rep    = '0;
    logic [NS-1:0] exp_errp   = '0;
    logic [NS-1:0] exp_rel    = '0;
    logic          exp_any    = 1'b0;
    logic          exp_relall = 1'b0;

    syncn_decoder_mc #(
        .NUM_SYNC   (NS),
        .REQ_FRAMES (RF),
        .CNT_W      (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_clk          (frame_clk),
        .i_sync_n           (i_sync_n),
`ifdef SYNCN_ERR_CNT_EN
        .i_err_cnt_clr      (i_err_cnt_clr),
        .o_err_cnt          (o_err_cnt),
`endif
        .o_sync_request_tx  (o_sync_request_tx),
        .o_err_reporting    (o_err_reporting),
        .o_err_pulse        (o_err_pulse),
        .o_sync_release     (o_sync_release),
        .o_sync_request_any (o_sync_request_any),
        .o_sync_release_all (o_sync_release_all)
    );

    always #5 clk = ~clk;

    function automatic logic [4*NS+1:0] dut_vec();
        return {o_sync_request_tx, o_err_reporting, o_err_pulse,
                o_sync_release, o_sync_request_any, o_sync_release_all};
    endfunction

    function automatic logic [4*NS+1:0] model_vec();
        return {exp_req, exp_rep, exp_errp, exp_rel, exp_any, exp_relall};
    endfunction

    // Drive one cycle of inputs, let the DUT sample them, advance the model
    // with the same inputs, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic r, input logic f,
                                 input logic [NS-1:0] s, input logic clr);
        logic [NS-1:0] prev_errp;
        rst       = r;
        frame_clk = f;
        i_sync_n  = s;
`ifdef SYNCN_ERR_CNT_EN
        i_err_cnt_clr = clr;
`endif
        @(posedge clk);
        prev_errp = exp_errp;
        for (int ch = 0; ch < NS; ch++) begin
            if (r) begin
                low_active[ch] = 1'b0;
                strobes[ch]    = 0;
                exp_req[ch]    = 1'b0;
                exp_rep[ch]    = 1'b0;
                exp_errp[ch]   = 1'b0;
                exp_rel[ch]    = 1'b0;
                exp_cnt[ch]    = 0;
            end else begin
                if (!s[ch]) begin
                    if (!low_active[ch]) begin
                        low_active[ch] = 1'b1;
                        strobes[ch]    = f ? 1 : 0;
                    end else if (f && strobes[ch] < RF) begin
                        strobes[ch]++;
                    end
                    exp_rep[ch]  = (strobes[ch] < RF);
                    exp_req[ch]  = (strobes[ch] == RF);
                    exp_errp[ch] = 1'b0;
                    exp_rel[ch]  = 1'b0;
                end else begin
                    exp_errp[ch]   = low_active[ch] && strobes[ch] > 0 && strobes[ch] < RF;
                    exp_rel[ch]    = low_active[ch] && strobes[ch] == RF;
                    low_active[ch] = 1'b0;
                    strobes[ch]    = 0;
                    exp_rep[ch]    = 1'b0;
                    exp_req[ch]    = 1'b0;
                end
                if (clr) exp_cnt[ch] = 0;
                else if (prev_errp[ch] && exp_cnt[ch] < CMAX) exp_cnt[ch]++;
            end
        end
        exp_any    = |exp_req;
        exp_relall = (|exp_rel) && !(|exp_req);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, '1, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", dut_vec(), '0);
        end
`ifdef SYNCN_ERR_CNT_EN
        vectors++;
        if (o_err_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_err_cnt: got %h expected 0", o_err_cnt);
        end
`endif
        applyStimulus(1'b0, 1'b0, '1, 1'b0);
        applyStimulus(1'b0, 1'b1, '1, 1'b0);
    endtask

    // Ch0 low for two strobes, then high: error report, never a request.
    task automatic test_err_report();
        logic seen_req = 1'b0;
        logic [3:0] frames = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, frames[i], 2'b10, 1'b0);
            seen_req |= o_sync_request_tx[0];
            vectors++;
            if (o_err_reporting[0] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL err_report_level step %0d: got %b expected 1", i, o_err_reporting[0]);
            end
        end
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
        vectors++;
        if ({o_err_pulse[0], o_err_reporting[0]} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL err_report_pulse: got pulse/level %b expected 10", {o_err_pulse[0], o_err_reporting[0]});
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        vectors++;
        if (o_err_pulse[0] !== 1'b0 || seen_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_report_after: got pulse %b req_seen %b expected 0 0", o_err_pulse[0], seen_req);
        end
    endtask

    // Ch1 low for six strobes: request after the fourth, release on rise.
    task automatic test_sync_request();
        int n = 0;
        for (int i = 0; i < 12; i++) begin
            logic f;
            f = (i % 2 == 0);
            applyStimulus(1'b0, f, 2'b01, 1'b0);
            if (f) n++;
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL sync_request step %0d: got %b expected %b", i, dut_vec(), model_vec());
            end
            if (f && n == RF) begin
                vectors++;
                if ({o_sync_request_tx[1], o_err_reporting[1]} !== 2'b10) begin
                    miscompares++;
                    $display("[TB] FAIL request_rise: got req/rep %b expected 10", {o_sync_request_tx[1], o_err_reporting[1]});
                end
            end
        end
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
        vectors++;
        if ({o_sync_release[1], o_sync_release_all, o_err_pulse[1], o_sync_request_tx[1]} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL request_release: got rel/all/errp/req %b expected 1100",
                     {o_sync_release[1], o_sync_release_all, o_err_pulse[1], o_sync_request_tx[1]});
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        vectors++;
        if ({o_sync_release[1], o_sync_release_all} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL release_one_cycle: got %b expected 00", {o_sync_release[1], o_sync_release_all});
        end
    endtask

    // One-cycle low between strobes: reporting for one cycle, no pulses.
    task automatic test_glitch();
        int rep_cycles = 0;
        logic any_pulse = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0);
        rep_cycles += int'(o_err_reporting[0]);
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
        rep_cycles += int'(o_err_reporting[0]);
        any_pulse |= o_err_pulse[0] | o_sync_release[0];
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        rep_cycles += int'(o_err_reporting[0]);
        any_pulse |= o_err_pulse[0] | o_sync_release[0];
        vectors++;
        if (rep_cycles != 1 || any_pulse !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch: got rep_cycles %0d pulse %b expected 1 0", rep_cycles, any_pulse);
        end
    endtask

    // Both channels in REQ; ch0 releases, ch1 three cycles later.
    task automatic test_both_release();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i % 2 == 0), 2'b00, 1'b0);
        end
        vectors++;
        if ({o_sync_request_tx, o_sync_request_any} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL both_req: got %b expected 111", {o_sync_request_tx, o_sync_request_any});
        end
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0);
        vectors++;
        if ({o_sync_release, o_sync_release_all, o_sync_request_any} !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL first_release: got rel/all/any %b expected 0101",
                     {o_sync_release, o_sync_release_all, o_sync_request_any});
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, (i % 2 == 0), 2'b01, 1'b0);
            vectors++;
            if ({o_sync_request_any, o_sync_release_all} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL any_hold step %0d: got any/all %b expected 10", i, {o_sync_request_any, o_sync_release_all});
            end
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        vectors++;
        if ({o_sync_release, o_sync_release_all, o_sync_request_any} !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL last_release: got rel/all/any %b expected 1010",
                     {o_sync_release, o_sync_release_all, o_sync_request_any});
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
    endtask

    // Reset while ch0 is low at count 3; count must restart afterwards.
    task automatic test_reset_mid();
        logic [4:0] frames = 5'b10101;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, frames[i], 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0);
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got %b expected %b", dut_vec(), '0);
        end
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0);
        vectors++;
        if ({o_err_reporting[0], o_err_pulse[0], o_sync_release[0]} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_fresh_fall: got rep/errp/rel %b expected 100",
                     {o_err_reporting[0], o_err_pulse[0], o_sync_release[0]});
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, (i % 2 == 0), 2'b10, 1'b0);
            vectors++;
            if (o_sync_request_tx[0] !== (i == 6)) begin
                miscompares++;
                $display("[TB] FAIL reset_recount step %0d: got req %b expected %b", i, o_sync_request_tx[0], (i == 6));
            end
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_release: got %b expected %b", dut_vec(), model_vec());
        end
    endtask

`ifdef SYNCN_ERR_CNT_EN
    // Five reports saturate a 2-bit counter; a clear on a pulse wins.
    task automatic test_err_cnt();
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
            applyStimulus(1'b0, 1'b0, 2'b10, 1'b0);
            applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
            applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        end
        vectors++;
        if (o_err_cnt[CW-1:0] !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_sat: got %0d expected 3", o_err_cnt[CW-1:0]);
        end
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b1);
        vectors++;
        if (o_err_cnt[CW-1:0] !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_clr: got %0d expected 0", o_err_cnt[CW-1:0]);
        end
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
        vectors++;
        if (o_err_cnt[CW-1:0] !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_after_clr: got %0d expected 0", o_err_cnt[CW-1:0]);
        end
    endtask
`endif

    // Random sticky SYNC~ levels, random strobes, occasional reset/clear.
    task automatic test_random();
        logic [NS-1:0] s = '1;
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < NS; ch++) begin
                if ($urandom_range(0, 6) == 0) s[ch] = ~s[ch];
            end
            applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                          s, ($urandom_range(0, 19) == 0));
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", i, dut_vec(), model_vec());
            end
`ifdef SYNCN_ERR_CNT_EN
            for (int ch = 0; ch < NS; ch++) begin
                vectors++;
                if (o_err_cnt[ch*CW +: CW] !== CW'(exp_cnt[ch])) begin
                    miscompares++;
                    $display("[TB] FAIL random err_cnt ch%0d cycle %0d: got %0d expected %0d",
                             ch, i, o_err_cnt[ch*CW +: CW], exp_cnt[ch]);
                end
            end
`endif
        end
    endtask

    initial begin
        for (int ch = 0; ch < NS; ch++) begin
            low_active[ch] = 1'b0;
            strobes[ch]    = 0;
            exp_cnt[ch]    = 0;
        end
        $display("[TB] starting syncn_decoder_mc bench");
        test_reset();
        test_err_report();
        test_sync_request();
        test_glitch();
        test_both_release();
        test_reset_mid();
`ifdef SYNCN_ERR_CNT_EN
        test_err_cnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
